// File: rtl/dmem_ctrl.sv
// Data-memory access controller: round-robin arbitration of two requesters, RV32I sub-word
// load extension and registered read-modify-write for byte/halfword stores.
module dmem_ctrl #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW+1:0] addr0_i,
  input  logic [AW+1:0] addr1_i,
  input  logic [2:0]    f3_0_i,
  input  logic [2:0]    f3_1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic          err0_o,
  output logic          err1_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_w_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i
);

  typedef enum logic [2:0] {StIdle, StAcc, StRd, StWr, StDone} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d, gnt_q, gnt_d;
  logic          we_q, we_d, err_q, err_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [DW-1:0] wdata_q, wdata_d, old_q, old_d, rdata_q, rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  logic          sel, s_we, s_unsup, s_mis;
  logic [AW+1:0] s_addr;
  logic [2:0]    s_f3;
  logic [DW-1:0] shifted, load_val, merged;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // Single requester wins outright; the pointer only breaks ties.
  assign sel    = (req0_i & req1_i) ? ptr_q : req1_i;
  assign s_we   = sel ? we1_i : we0_i;
  assign s_addr = sel ? addr1_i : addr0_i;
  assign s_f3   = sel ? f3_1_i : f3_0_i;

  assign s_unsup = (s_f3 == 3'b011) || (s_f3 == 3'b110) || (s_f3 == 3'b111);
  assign s_mis   = ((s_f3[1:0] == 2'b01) && s_addr[0]) ||
                   ((s_f3 == 3'b010) && (s_addr[1:0] != 2'b00));

  assign shifted = mem_dout_i >> {addr_q[1:0], 3'b000};
  assign ld_b    = shifted[7:0];
  assign ld_h    = addr_q[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];

  always_comb begin
    load_val = mem_dout_i;
    unique case (f3_q)
      3'b000:  load_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  load_val = {24'h0, ld_b};
      3'b001:  load_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  load_val = {16'h0, ld_h};
      default: load_val = mem_dout_i;
    endcase
  end

  always_comb begin
    merged = old_q;
    if (f3_q[0] == 1'b0) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_w_en_o = 1'b0;
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    err0_o     = 1'b0;
    err1_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          gnt_d   = sel;
          ptr_d   = ~sel;
          we_d    = s_we;
          addr_d  = s_addr;
          f3_d    = s_f3;
          wdata_d = sel ? wdata1_i : wdata0_i;
          err_d   = s_unsup || s_mis;
          if (s_unsup || s_mis)            state_d = StDone;
          else if (!s_we || s_f3 == 3'b010) state_d = StAcc;
          else                              state_d = StRd;
        end
      end
      StAcc: begin
        mem_addr_d = addr_q[AW+1:2];
        if (we_q) begin
          mem_w_en_o = 1'b1;
          mem_din_d  = wdata_q;
        end else begin
          rdata_d = load_val;
        end
        state_d = StDone;
      end
      StRd: begin
        mem_addr_d = addr_q[AW+1:2];
        old_d      = mem_dout_i;
        state_d    = StWr;
      end
      StWr: begin
        mem_addr_d = addr_q[AW+1:2];
        mem_w_en_o = 1'b1;
        mem_din_d  = merged;
        state_d    = StDone;
      end
      StDone: begin
        ack0_o  = ~gnt_q;
        ack1_o  = gnt_q;
        err0_o  = ~gnt_q & err_q;
        err1_o  = gnt_q & err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address/data lines follow the active state and hold their last value otherwise.
  assign mem_addr_o = mem_addr_d;
  assign mem_din_o  = mem_din_d;
  assign rdata_o    = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural word memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [17:0] addr0 = '0, addr1 = '0;
  logic [2:0]  f3_0 = '0, f3_1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, mem_w_en;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [15:0] mem_addr;

  logic [31:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_din;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign mem_dout = mem[mem_addr];

  dmem_ctrl #(.AW(16), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .f3_0_i(f3_0), .f3_1_i(f3_1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .err0_o(err0), .err1_o(err1),
    .rdata_o(rdata), .mem_w_en_o(mem_w_en), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request on port 0 and reports the ack cycle (edge 0 = IDLE sampling edge).
  task automatic xact(input logic we, input logic [17:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, output int cyc, output logic err,
                      output logic [31:0] rd, output int nwen, output logic [15:0] waddr);
    @(negedge clk);
    req0 = 1'b1; we0 = we; addr0 = a; f3_0 = f3; wdata0 = wd;
    cyc = -1; err = 1'b0; rd = '0; nwen = 0; waddr = '0;
    for (int c = 1; c <= 12 && cyc < 0; c++) begin
      @(negedge clk);
      if (mem_w_en) begin nwen++; waddr = mem_addr; end
      if (ack0) begin cyc = c; err = err0; rd = rdata; req0 = 1'b0; end
    end
    req0 = 1'b0;
  endtask

  int          cyc, nwen, n, c0, c1;
  logic        err;
  logic [31:0] rd, rd1;
  logic [15:0] waddr;
  logic        order [4];
  logic        both  [4];
  logic [31:0] rds   [4];
  logic [31:0] exp_rd;

  initial begin
    @(negedge clk);
    check("rst_flags", {27'h0, ack0, ack1, err0, err1, mem_w_en}, 32'h0);
    check("rst_maddr", {16'h0, mem_addr}, 32'h0);
    check("rst_mdin", mem_din, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    xact(1'b1, 18'h0010, 3'b010, 32'hDEADBEEF, cyc, err, rd, nwen, waddr);
    check("sw_cyc", cyc, 32'd2);
    check("sw_nwen", nwen, 32'd1);
    check("sw_waddr", {16'h0, waddr}, 32'd4);
    check("sw_err", {31'h0, err}, 32'd0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    xact(1'b0, 18'h0010, 3'b010, 32'h0, cyc, err, rd, nwen, waddr);
    check("lw_cyc", cyc, 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_nwen", nwen, 32'd0);

    preload(16'h0, 32'h11223344);
    xact(1'b1, 18'h0001, 3'b000, 32'h000000AA, cyc, err, rd, nwen, waddr);
    check("sb_cyc", cyc, 32'd3);
    check("sb_nwen", nwen, 32'd1);
    check("sb_mem", mem[0], 32'h1122AA44);
    xact(1'b0, 18'h0001, 3'b000, 32'h0, cyc, err, rd, nwen, waddr);
    check("lb_rdata", rd, 32'hFFFFFFAA);
    xact(1'b0, 18'h0001, 3'b100, 32'h0, cyc, err, rd, nwen, waddr);
    check("lbu_rdata", rd, 32'h000000AA);
    xact(1'b0, 18'h0002, 3'b001, 32'h0, cyc, err, rd, nwen, waddr);
    check("lh_rdata", rd, 32'h00001122);

    xact(1'b0, 18'h0002, 3'b010, 32'h0, cyc, err, rd, nwen, waddr);
    check("mis_lw_cyc", cyc, 32'd1);
    check("mis_lw_err", {31'h0, err}, 32'd1);
    check("mis_lw_nwen", nwen, 32'd0);
    xact(1'b1, 18'h0003, 3'b001, 32'h0000FFFF, cyc, err, rd, nwen, waddr);
    check("mis_sh_cyc", cyc, 32'd1);
    check("mis_sh_err", {31'h0, err}, 32'd1);
    check("mis_sh_nwen", nwen, 32'd0);
    check("mis_sh_mem", mem[0], 32'h1122AA44);
    xact(1'b1, 18'h0000, 3'b011, 32'h0, cyc, err, rd, nwen, waddr);
    check("unsup_cyc", cyc, 32'd1);
    check("unsup_err", {31'h0, err}, 32'd1);
    check("unsup_nwen", nwen, 32'd0);
    check("unsup_mem", mem[0], 32'h1122AA44);
    check("err_rdata_hold", rdata, 32'h00001122);

    // Both ports held: pointer restarts at port 0 after reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h0010; f3_0 = 3'b010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'h0000; f3_1 = 3'b010;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        order[n] = ack1; both[n] = ack0 & ack1; rds[n] = rdata; n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("arb_count", n, 32'd4);
    for (int i = 0; i < n; i++) begin
      exp_rd = (i % 2 == 1) ? 32'h1122AA44 : 32'hDEADBEEF;
      check("arb_gnt", {31'h0, order[i]}, i % 2);
      check("arb_excl", {31'h0, both[i]}, 32'd0);
      check("arb_rdata", rds[i], exp_rd);
    end

    preload(16'h1, 32'h55667788);
    xact(1'b1, 18'h0006, 3'b001, 32'h0000BEEF, cyc, err, rd, nwen, waddr);
    check("sh_cyc", cyc, 32'd3);
    check("sh_mem", mem[1], 32'hBEEF7788);

    // Same store again, aborted by reset while in WR.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h0006; f3_0 = 3'b001; wdata0 = 32'h00001234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_flags", {27'h0, ack0, ack1, err0, err1, mem_w_en}, 32'h0);
    check("abort_maddr", {16'h0, mem_addr}, 32'h0);
    check("abort_mdin", mem_din, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1 || mem_w_en) n++;
    end
    check("abort_noack", n, 32'd0);
    check("abort_mem", mem[1], 32'hBEEF7788);

    // Port 1 load arrives while port 0 runs a byte store.
    preload(16'h8, 32'h00000000);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h0020; f3_0 = 3'b000; wdata0 = 32'h0000005A;
    c0 = -1; c1 = -1; rd1 = '0;
    for (int c = 1; c <= 15 && c1 < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h0020; f3_1 = 3'b010;
      end
      if (ack0) begin c0 = c; req0 = 1'b0; end
      if (ack1) begin c1 = c; rd1 = rdata; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("hold_ack0_cyc", c0, 32'd3);
    check("hold_ack1_cyc", c1, 32'd6);
    check("hold_rdata", rd1, 32'h0000005A);
    check("hold_mem", mem[8], 32'h0000005A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
